// File: rtl/fft_pass_counter.sv
// Beat/pass counter for a 256-point FFT stage: counts valid beats up to a runtime
// threshold, then counts threshold wraps as passes, pulsing full/done on completion.
module fft_pass_counter #(
    parameter int CNT_W      = 8,
    parameter int PASS_W     = 3,
    parameter int NUM_PASSES = 8,
    parameter int AUTO_RST   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              start,
    input  logic              stop,
    input  logic              valid,
    output logic [CNT_W-1:0]  cnt,
    output logic [PASS_W-1:0] pass,
    output logic              busy,
    output logic              not_zero,
    output logic              full,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   thresh_q, thresh_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [PASS_W-1:0]  pass_n;
    logic               full_n, done_n, err_n;

    always_comb begin
        state_n  = state;
        thresh_n = thresh_q;
        cnt_n    = cnt;
        pass_n   = pass;
        full_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        if (stop) begin
            // stop wins over start and over a wrapping beat in the same cycle
            state_n = IDLE;
            cnt_n   = '0;
            pass_n  = '0;
        end else if (state == IDLE) begin
            if (start) begin
                if (thresh != '0) begin
                    state_n  = RUN;
                    thresh_n = thresh;
                    cnt_n    = '0;
                    pass_n   = '0;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (valid) begin
            if (cnt == thresh_q - CNT_W'(1)) begin
                cnt_n  = '0;
                full_n = 1'b1;
                if (pass == LAST_PASS) begin
                    done_n = 1'b1;
                    pass_n = '0;
                    if (AUTO_RST == 0)
                        state_n = IDLE;
                end else begin
                    pass_n = pass + PASS_W'(1);
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    // busy/not_zero are registered from next-state values so they line up with cnt/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            thresh_q <= '0;
            cnt      <= '0;
            pass     <= '0;
            busy     <= 1'b0;
            not_zero <= 1'b0;
            full     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            thresh_q <= thresh_n;
            cnt      <= cnt_n;
            pass     <= pass_n;
            busy     <= (state_n == RUN);
            not_zero <= (cnt_n != '0);
            full     <= full_n;
            done     <= done_n;
            cfg_err  <= err_n;
        end
    end

endmodule
